// File: rtl/mul_add_pkg.sv
// mul_add_pkg: shared widths, iteration count and FSM states for mul_add_16bit
package mul_add_pkg;
    localparam int Q_W   = 16;
    localparam int B_W   = 8;
    localparam int R_W   = 16;
    localparam int ACC_W = 24;
    localparam int ITER  = 8;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/mul_add_step.sv
// mul_add_step: one combinational shift-add iteration over the low divisor bit
module mul_add_step
    import mul_add_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] mcand,
    input  logic [B_W-1:0]   mb,
    output logic [ACC_W-1:0] acc_nxt,
    output logic [ACC_W-1:0] mcand_nxt,
    output logic [B_W-1:0]   mb_nxt
);
    assign acc_nxt   = mb[0] ? acc + mcand : acc;
    assign mcand_nxt = mcand << 1;
    assign mb_nxt    = mb >> 1;
endmodule

// File: rtl/mul_add_16bit.sv
// mul_add_16bit: sequential product = Q*B + R; MUL_ADD_EARLY_EXIT_EN enables data-dependent early exit
module mul_add_16bit
    import mul_add_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [15:0]  Q,
    input  logic [7:0]   B,
    input  logic [15:0]  R,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [23:0]  product,
    output logic [15:0]  A,
    output logic         ovf,
    output logic         rem_err
);
    state_t state, state_nxt;
    logic [ACC_W-1:0] acc, mcand, acc_nxt, mcand_nxt, product_r;
    logic [B_W-1:0]   mb, mb_nxt;
    logic [2:0]       cnt;
    logic             rem_err_r, rem_err_q, accept, last, skip;

    mul_add_step u_step (
        .acc(acc), .mcand(mcand), .mb(mb),
        .acc_nxt(acc_nxt), .mcand_nxt(mcand_nxt), .mb_nxt(mb_nxt)
    );

`ifdef MUL_ADD_EARLY_EXIT_EN
    assign skip = B == '0;
    assign last = (cnt == 3'(ITER - 1)) || (mb_nxt == '0);
`else
    assign skip = 1'b0;
    assign last = cnt == 3'(ITER - 1);
`endif

    assign in_ready  = rst_n && state == IDLE;
    assign out_valid = state == DONE;
    assign accept    = in_valid && in_ready;
    assign product   = product_r;
    assign A         = product_r[15:0];
    assign ovf       = |product_r[23:16];
    assign rem_err   = rem_err_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = in_valid ? (skip ? DONE : CALC) : IDLE;
            CALC:    state_nxt = last ? DONE : CALC;
            DONE:    state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mb        <= '0;
            cnt       <= '0;
            rem_err_r <= 1'b0;
            rem_err_q <= 1'b0;
            product_r <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                acc       <= {8'b0, R};
                mcand     <= {8'b0, Q};
                mb        <= B;
                cnt       <= '0;
                rem_err_r <= R >= 16'(B);
                // B == 0 with early exit: the product is just R
                if (skip) begin
                    product_r <= {8'b0, R};
                    rem_err_q <= 1'b1;
                end
            end else if (state == CALC) begin
                acc   <= acc_nxt;
                mcand <= mcand_nxt;
                mb    <= mb_nxt;
                cnt   <= cnt + 3'd1;
                if (last) begin
                    product_r <= acc_nxt;
                    rem_err_q <= rem_err_r;
                end
            end
        end
    end
endmodule

// File: tb/tb_mul_add_16bit.sv
// tb_mul_add_16bit: table, corner-sequence and random checks against an arithmetic model
module tb_mul_add_16bit;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, ovf, rem_err;
    logic [15:0] Q = '0, R = '0, A;
    logic [7:0]  B = '0;
    logic [23:0] product;
    int          n_cmp = 0, n_bad = 0;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  b;
        logic [15:0] r;
        logic [23:0] p;
        logic        re;
    } vec_t;
    vec_t vecs[7];

    mul_add_16bit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .Q(Q), .B(B), .R(R), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .A(A), .ovf(ovf), .rem_err(rem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // edges counted from the acceptance edge as edge 1
    function automatic int exp_lat(input logic [7:0] b);
`ifdef MUL_ADD_EARLY_EXIT_EN
        if (b == 0) return 1;
        for (int i = 7; i >= 0; i--) if (b[i]) return i + 2;
`endif
        return 9;
    endfunction

    task automatic accept_op(input logic [15:0] q, input logic [7:0] b, input logic [15:0] r);
        int k = 0;
        Q = q; B = b; R = r; in_valid = 1'b1;
        while (!in_ready && k < 40) begin @(negedge clk); k++; end
        check("accept_wait", 32'(k < 40), 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic finish_op(input logic [23:0] p, input logic re, input int lat_exp);
        int lat = 1;
        while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
        check("latency", 32'(lat), 32'(lat_exp));
        check("product", 32'(product), 32'(p));
        check("A", 32'(A), 32'(p[15:0]));
        check("ovf", 32'(ovf), 32'(|p[23:16]));
        check("rem_err", 32'(rem_err), 32'(re));
        check("busy_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("product_hold", 32'(product), 32'(p));
    endtask

    initial begin
        logic [15:0] q, r;
        logic [7:0]  b;
        logic [23:0] p;
        int          seen, lat;
        vecs[0] = '{16'd100,   8'd7,    16'd3,     24'd703,     1'b0};
        vecs[1] = '{16'hFFFF,  8'hFF,   16'h00FE,  24'hFEFFFF,  1'b0};
        vecs[2] = '{16'd5,     8'd0,    16'd9,     24'd9,       1'b1};
        vecs[3] = '{16'd0,     8'd0,    16'd0,     24'd0,       1'b1};
        vecs[4] = '{16'd0,     8'd1,    16'd0,     24'd0,       1'b0};
        vecs[5] = '{16'd1,     8'd128,  16'd127,   24'd255,     1'b0};
        vecs[6] = '{16'hFFFF,  8'hFF,   16'hFFFF,  24'hFFFF00,  1'b1};

        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_rem_err", 32'(rem_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) begin
            accept_op(vecs[i].q, vecs[i].b, vecs[i].r);
            in_valid = 1'b0;
            finish_op(vecs[i].p, vecs[i].re, exp_lat(vecs[i].b));
        end

        // backpressure, with a new request pending during DONE
        out_ready = 1'b0;
        accept_op(16'd3, 8'd4, 16'd10);
        Q = 16'd2; B = 8'd2; R = 16'd1;
        lat = 1;
        while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
        check("bp_latency", 32'(lat), 32'(exp_lat(8'd4)));
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_product", 32'(product), 32'd22);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_next_accepted", 32'(in_ready), 32'd0);
        finish_op(24'd5, 1'b0, exp_lat(8'd2));

        // reset in the middle of a calculation
        accept_op(16'd1000, 8'd200, 16'd0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_product", 32'(product), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_rem_err", 32'(rem_err), 32'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin @(negedge clk); if (out_valid) seen++; end
        check("midrst_no_result", 32'(seen), 32'd0);
        accept_op(16'd1, 8'd1, 16'd0);
        in_valid = 1'b0;
        finish_op(24'd1, 1'b0, exp_lat(8'd1));

        // back-to-back random operations, in_valid never dropped
        for (int i = 0; i < 24; i++) begin
            q = 16'($urandom);
            b = (i % 6 == 0) ? 8'd0 : 8'($urandom);
            r = (i % 4 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            p = 24'(q) * 24'(b) + 24'(r);
            accept_op(q, b, r);
            finish_op(p, r >= 16'(b), exp_lat(b));
        end
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
